// File: rtl/single_port_lutram_requester.sv
// single_port_lutram_requester: valid/ready front end for a single-port LUTRAM with a 3-deep read response FIFO and a fill sweep.
module single_port_lutram_requester #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SETS),
  parameter logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] FILL_VALUE = '0
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   flush_in,
  output logic                                   flush_busy_out,
  input  logic                                   req_valid_in,
  output logic                                   req_ready_out,
  input  logic                                   req_write_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       req_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req_data_in,
  output logic                                   resp_valid_out,
  input  logic                                   resp_ready_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] resp_data_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       resp_addr_out,
  output logic                                   ram_access_en_out,
  output logic                                   ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_access_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in
);
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] cnt_q, raddr_q;
  logic inflight_q;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] fdata_q [3];
  logic [SET_PTR_WIDTH_IN_BITS-1:0] faddr_q [3];
  logic [1:0] wr_q, rd_q, count_q;
  logic sweep, accept, pop;
  assign sweep = state_q == SWEEP;
  // An outstanding read holds a FIFO slot so its data always has somewhere to land
  assign req_ready_out = !sweep && (3'(count_q) + 3'(inflight_q) < 3'd3);
  assign accept = req_valid_in && req_ready_out;
  assign resp_valid_out = count_q != 2'd0;
  assign pop = resp_valid_out && resp_ready_in;
  assign resp_data_out = resp_valid_out ? fdata_q[rd_q] : '0;
  assign resp_addr_out = resp_valid_out ? faddr_q[rd_q] : '0;
  assign flush_busy_out = sweep;
  assign ram_access_en_out = sweep || accept;
  assign ram_write_en_out = sweep || req_write_in;
  assign ram_access_set_addr_out = sweep ? cnt_q : req_addr_in;
  assign ram_write_element_out = sweep ? FILL_VALUE : req_data_in;
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      raddr_q <= '0;
      inflight_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      inflight_q <= accept && !req_write_in;
      if (accept) raddr_q <= req_addr_in;
      if (inflight_q) begin
        fdata_q[wr_q] <= ram_read_element_in;
        faddr_q[wr_q] <= raddr_q;
        wr_q <= wr_q == 2'd2 ? 2'd0 : wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q == 2'd2 ? 2'd0 : rd_q + 2'd1;
      count_q <= count_q + 2'(inflight_q) - 2'(pop);
      if (!sweep) begin
        if (flush_in) state_q <= SWEEP;
      end else begin
        cnt_q <= cnt_q == LAST_SET ? '0 : cnt_q + SET_PTR_WIDTH_IN_BITS'(1);
        if (cnt_q == LAST_SET) state_q <= IDLE;
      end
    end
  end
endmodule

// File: doc/single_port_lutram_requester.md
Name: single_port_lutram_requester

Overview:
- Initiator-side controller for a single-port LUTRAM.
- Accepts read/write requests on a valid/ready interface and drives the RAM port (access_en / write_en / set addr / write element).
- Captures the 1-cycle-latency read data into a 3-entry response FIFO with backpressure.
- Provides a flush sweep that writes FILL_VALUE to every set.

Parameters:
- SINGLE_ELEMENT_SIZE_IN_BITS, 64, data width.
- NUMBER_SETS, 64, RAM depth.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS), address width.
- FILL_VALUE, 0, element value written by the flush sweep.

Ports:
- clk_in  input  1  clock; all state on posedge.
- reset_in  input  1  synchronous, active-high reset.
- flush_in  input  1  pulse; start a sweep.
- flush_busy_out  output  1  high while the sweep owns the RAM port.
- req_valid_in  input  1  request valid.
- req_ready_out  output  1  request accepted when valid&&ready.
- req_write_in  input  1  1=write, 0=read.
- req_addr_in  input  SET_PTR_WIDTH_IN_BITS  set address.
- req_data_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  write data.
- resp_valid_out  output  1  FIFO head valid.
- resp_ready_in  input  1  consumer pops the head when valid&&ready.
- resp_data_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  read data at head.
- resp_addr_out  output  SET_PTR_WIDTH_IN_BITS  address of the head read.
- ram_access_en_out  output  1  to RAM access_en.
- ram_write_en_out  output  1  to RAM write_en.
- ram_access_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  to RAM set addr.
- ram_write_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  to RAM write data.
- ram_read_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  from RAM read data; valid the cycle after a read access.

Behaviour:
- Reset: state=IDLE, sweep counter=0, read-inflight flag=0, FIFO empty. resp_valid_out=0, resp_data_out=0, resp_addr_out=0, flush_busy_out=0.
- States: IDLE, SWEEP.
- IDLE, request path:
  - req_ready_out = (state==IDLE) && (inflight + fifo_count < 3).
  - Combinational only from registered state; no dependence on req_valid_in, req_write_in or resp_ready_in.
- IDLE, RAM drive:
  - ram_access_en_out = req_valid_in && req_ready_out.
  - ram_write_en_out = req_write_in.
  - ram_access_set_addr_out = req_addr_in.
  - ram_write_element_out = req_data_in.
  - All combinational passthrough.
- Accepted write: takes effect at that edge. No response. Does not use the inflight credit but is gated by the same ready.
- Accepted read at cycle T:
  - inflight=1 and the address is registered.
  - At T+1, ram_read_element_in plus the registered address are pushed into the FIFO.
  - Earliest resp_valid_out is T+2 (registered FIFO head).
- Credit rule guarantees the FIFO never overflows. Push and pop in the same cycle are allowed, with count unchanged.
- Sustained rate with resp_ready_in=1: one read per cycle.
- FIFO ordering is strict in-order. Head data/addr hold stable while resp_valid_out=1 and resp_ready_in=0.
- Write then read of the same addr on consecutive cycles returns the new data.
- Sweep entry: flush_in=1 in IDLE at cycle T.
  - Any request accepted in cycle T completes normally.
  - Sweep begins at T+1.
- Sweep operation:
  - Cycles T+1..T+NUMBER_SETS: flush_busy_out=1, ram_access_en_out=1, ram_write_en_out=1, ram_access_set_addr_out=counter (0..NUMBER_SETS-1), ram_write_element_out=FILL_VALUE.
  - req_ready_out=0 throughout.
- Sweep exit: at T+NUMBER_SETS+1, state=IDLE and the counter wraps to 0.
- During SWEEP:
  - flush_in is ignored.
  - An in-flight read's data is still captured at the cycle after its issue; the RAM holds its output.
  - The FIFO continues to drain.
- reset_in mid-operation (any state): aborts the sweep and discards the inflight read and all FIFO contents. Outputs return to reset values the next cycle.

Test Plan:
- Write addr 5 = 0xDEAD_BEEF, next cycle read addr 5, resp_ready_in=1 -> resp_valid_out=1 two cycles after the read issue, with resp_data_out=0xDEAD_BEEF and resp_addr_out=5.
- Write addrs 0..7 = addr*0x11, then 8 back-to-back reads with resp_ready_in=1 -> req_ready_out stays 1 and 8 in-order responses arrive on consecutive cycles.
- resp_ready_in=0, issue reads continuously -> exactly 3 accepted, then req_ready_out=0. After raising resp_ready_in, all 3 responses arrive in order and acceptance resumes.
- Fill RAM with nonzero data, pulse flush_in (FILL_VALUE=0) -> flush_busy_out high for exactly 64 cycles with addrs 0..63 written. req_ready_out=0 during the sweep. Subsequent reads of addrs 0, 31, 63 return 0.
- flush_in and an accepted read to addr 9 in the same cycle -> the read response carries the pre-flush data of addr 9, and the sweep starts the next cycle.
- Assert reset_in at sweep cycle 20 while 2 responses are pending -> the next cycle shows flush_busy_out=0, resp_valid_out=0, req_ready_out=1, and no stale responses later.
